// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, one stop bit.
// Each bit is held for Prescale clock cycles (0 selects 64).
module uart_tx (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] Prescale,
    output logic       TX_OUT,
    output logic       Busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic               tx_d;
    logic               busy_d;

    logic [CNT_W-1:0]   presc_m1_c;
    logic               bit_end_c;
    logic               parity_c;

    // Prescale of 0 wraps to 63 here, giving a 64-cycle bit.
    assign presc_m1_c = presc_q - CNT_W'(1);
    assign bit_end_c  = (edge_q == presc_m1_c);
    assign parity_c   = (^data_q) ^ par_typ_q;

    // State, counters, latched frame config and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            TX_OUT    <= tx_d;
            Busy      <= busy_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d   = state_q;
        edge_d    = bit_end_c ? '0 : edge_q + CNT_W'(1);
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        presc_d   = presc_q;
        tx_d      = 1'b1;
        busy_d    = 1'b1;

        case (state_q)
            IDLE: begin
                edge_d = '0;
                idx_d  = '0;
                if (Data_Valid) begin
                    state_d   = START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    presc_d   = Prescale;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the line changes on the same edge.
        case (state_d)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = parity_c;
            STOP:    tx_d = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one 8-bit word per frame onto `TX_OUT` as start bit, 8 data bits LSB-first, optional parity bit and one stop bit. It is the transmit end of the UART link whose receiver takes the same `Prescale`, `PAR_EN` and `PAR_TYP` configuration. It is clocked by the same oversampling clock as the receiver, so each bit is held for `Prescale` `CLK` cycles. A single `Busy` output is the only flow control; there is no internal queue.

## Interface
- No parameters; data width is fixed at 8, with 1 stop bit.
- `CLK`  input  1  single clock, rising edge; same oversampling clock as the receiver.
- `RST`  input  1  asynchronous, active-low reset.
- `P_DATA`  input  8  word to send; sampled only on acceptance.
- `Data_Valid`  input  1  send request; accepted only when `Busy`=0.
- `PAR_EN`  input  1  1 = insert parity bit.
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity.
- `Prescale`  input  6  `CLK` cycles per bit; 0 means 64.
- `TX_OUT`  output  1  serial line, idle high; registered.
- `Busy`  output  1  high while a frame is in progress; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **Acceptance:** occurs at a rising edge where the state is IDLE and `Data_Valid`=1.
  - Latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` into internal registers.
  - Later changes to these inputs have no effect on the frame in flight.
- **Parity:** computed from latched data.
  - Even (`PAR_TYP`=0): parity bit = XOR of data bits.
  - Odd (`PAR_TYP`=1): parity bit = inverted XOR of data bits.
- **Edge counter:** 6 bits; counts 0 .. (latched `Prescale` − 1) modulo 64, so `Prescale`=0 gives 64-cycle bits.
  - A bit ends when the edge counter equals `Prescale`−1; the counter then wraps to 0.
- **Bit counter:** 3 bits; indexes data bits 0..7 in DATA.
- **Transitions:**
  - IDLE→START on acceptance.
  - START→DATA at bit end.
  - DATA→DATA at bit end while bit index < 7 (index increments).
  - DATA→PARITY at bit end of bit 7 if latched `PAR_EN`=1; otherwise DATA→STOP.
  - PARITY→STOP at bit end.
  - STOP→IDLE at bit end.
- **`TX_OUT` per state:** IDLE 1, START 0, DATA latched bit[index], PARITY parity bit, STOP 1.
- `Busy` = 1 in every state except IDLE.
- `Data_Valid` while `Busy`=1 is ignored. The request is not remembered; the source must re-assert it after `Busy` falls.
- **Reset:**
  - Assertion at any time, including mid-frame, immediately forces IDLE, `TX_OUT`=1, `Busy`=0, and clears both counters and all latched registers.
  - No partial frame resumes after reset is released.

## Timing
- Reset values: `TX_OUT`=1, `Busy`=0.
- Let the acceptance edge be E.
  - `TX_OUT` goes 0 and `Busy` goes 1 directly after E (registered at E); zero added latency.
- Each bit holds for exactly P = latched `Prescale` cycles (64 if 0).
- Data bit i starts at E + (1+i)·P.
- Parity bit (if enabled) starts at E + 9·P.
- Stop bit starts at E + 9·P, or E + 10·P with parity.
- Frame length is 10·P cycles, or 11·P with parity.
  - At E + 10·P (or 11·P), `Busy` falls to 0 and `TX_OUT` stays 1.
- Back-to-back: with `Data_Valid` held high, the next acceptance occurs at the first edge where `Busy`=0.
  - This gives exactly 1 idle-high `CLK` cycle between the stop bit and the next start bit.
  - Frame period is therefore 10·P+1 cycles (11·P+1 with parity).
- `Data_Valid` asserted in the same cycle `Busy` falls is accepted on that edge (state is IDLE).

## Test plan
- **Reset:** hold `RST`=0 with random inputs → `TX_OUT`=1, `Busy`=0 throughout; release with `Data_Valid`=0 → line stays idle.
- **Even parity:** `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, `Prescale`=8, one-cycle `Data_Valid`.
  - Required: `TX_OUT` sequence 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each held exactly 8 cycles.
  - Required: `Busy` high for 88 cycles.
- **Odd parity / no parity:** same word with `PAR_TYP`=1 → parity bit 1.
  - Then `PAR_EN`=0, `Prescale`=16 → 10-bit frame, `Busy` high exactly 160 cycles, no parity slot.
- **Ignored request and config change:** pulse `Data_Valid` with `P_DATA`=0x3C mid-frame, and change `PAR_EN`, `Prescale` and `P_DATA` mid-frame.
  - Required: current frame unchanged; no second frame follows.
- **Back-to-back:** `Data_Valid` held high, `P_DATA`=0x00 then 0xFF, `PAR_EN`=0, `Prescale`=4.
  - Required: two 40-cycle frames separated by exactly 1 high cycle; second frame carries 0xFF.
- **Reset mid-frame and `Prescale`=0:** assert `RST` during data bit 3 → `TX_OUT`=1 and `Busy`=0 within the same cycle, before the next edge.
  - After release, send 0x01 with `Prescale`=0 → each bit held 64 cycles.
